// File: rtl/conv_channel_acc_scheduler.sv
// Channel-in accumulation sequencer: reads one IMAGE_SIZE plane per channel, 1-cycle beat latency, GAP idle cycles between planes.
// Reads stall while in_fifo_empty; result gating follows acc_valid. CONV_SCHED_STALL_CNT_EN adds a stall_cycles counter.
module conv_channel_acc_scheduler #(
  parameter int IMAGE_SIZE     = 256,
  parameter int CHANNEL_NUM_IN = 128,
  parameter int IMAGE_WIDTH    = 16,
  parameter int RATE           = 1,
  parameter int PTR_W          = $clog2(IMAGE_SIZE) + 1,
  parameter int CH_W           = $clog2(CHANNEL_NUM_IN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_fifo_full,
  input  logic            in_fifo_empty,
  input  logic            acc_valid,
  output logic            in_rd_en,
  output logic            psum_rd_en,
  output logic            beat_valid,
  output logic            sel_zero,
  output logic            out_en,
  output logic            busy,
  output logic            done,
`ifdef CONV_SCHED_STALL_CNT_EN
  output logic [CH_W-1:0] cnt_channel,
  output logic [15:0]     stall_cycles
`else
  output logic [CH_W-1:0] cnt_channel
`endif
);

  localparam int GAP   = IMAGE_WIDTH * RATE + RATE;
  localparam int GAP_W = $clog2(GAP) + 1;

  localparam logic [PTR_W-1:0] PIX_LAST = PTR_W'(IMAGE_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM_IN - 1);
  localparam logic [CH_W-1:0]  CH_END   = CH_W'(CHANNEL_NUM_IN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_READ,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] cnt_pixel_q, cnt_pixel_d;
  logic [CH_W-1:0]  cnt_channel_q, cnt_channel_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0] res_pixel_q, res_pixel_d;
  logic [CH_W-1:0]  res_channel_q, res_channel_d;
  logic             beat_valid_q, beat_valid_d;
  logic             sel_zero_q, sel_zero_d;
  logic             res_active;

  always_comb begin
    state_d       = state_q;
    cnt_pixel_d   = cnt_pixel_q;
    cnt_channel_d = cnt_channel_q;
    gap_cnt_d     = gap_cnt_q;
    res_pixel_d   = res_pixel_q;
    res_channel_d = res_channel_q;
    in_rd_en      = 1'b0;
    psum_rd_en    = 1'b0;

    // Adder results only count once the plane is streaming; stray acc_valid in IDLE/FILL is dropped.
    res_active = (state_q == S_READ) || (state_q == S_GAP) || (state_q == S_DRAIN);
    out_en     = acc_valid && res_active && (res_channel_q == CH_LAST);
    if (acc_valid && res_active && (res_channel_q != CH_END)) begin
      if (res_pixel_q == PIX_LAST) begin
        res_pixel_d   = '0;
        res_channel_d = res_channel_q + 1'b1;
      end else begin
        res_pixel_d = res_pixel_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_FILL;
          cnt_pixel_d   = '0;
          cnt_channel_d = '0;
          gap_cnt_d     = '0;
          res_pixel_d   = '0;
          res_channel_d = '0;
        end
      end
      S_FILL: begin
        if (in_fifo_full && !in_fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        if (!in_fifo_empty) begin
          in_rd_en   = 1'b1;
          psum_rd_en = (cnt_channel_q != '0);
          if (cnt_pixel_q == PIX_LAST) begin
            cnt_pixel_d = '0;
            gap_cnt_d   = '0;
            state_d     = S_GAP;
          end else begin
            cnt_pixel_d = cnt_pixel_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d     = '0;
          cnt_channel_d = cnt_channel_q + 1'b1;
          state_d       = (cnt_channel_d == CH_END) ? S_DRAIN : S_READ;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Looking at the next count lets done follow the final out_en by exactly one cycle.
        if (res_channel_d == CH_END) state_d = S_DONE;
      end
      S_DONE: begin
        state_d       = S_IDLE;
        cnt_pixel_d   = '0;
        cnt_channel_d = '0;
        gap_cnt_d     = '0;
        res_pixel_d   = '0;
        res_channel_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    beat_valid_d = in_rd_en;
    sel_zero_d   = in_rd_en && (cnt_channel_q == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_pixel_q   <= '0;
      cnt_channel_q <= '0;
      gap_cnt_q     <= '0;
      res_pixel_q   <= '0;
      res_channel_q <= '0;
      beat_valid_q  <= 1'b0;
      sel_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_pixel_q   <= cnt_pixel_d;
      cnt_channel_q <= cnt_channel_d;
      gap_cnt_q     <= gap_cnt_d;
      res_pixel_q   <= res_pixel_d;
      res_channel_q <= res_channel_d;
      beat_valid_q  <= beat_valid_d;
      sel_zero_q    <= sel_zero_d;
    end
  end

  assign beat_valid  = beat_valid_q;
  assign sel_zero    = sel_zero_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign cnt_channel = cnt_channel_q;

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q == S_IDLE) && start) begin
      stall_cycles_d = '0;
    end else if ((state_q == S_READ) && in_fifo_empty && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
